// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-digit up/down counter.
package bcd_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // Count direction, matching the encoding of the mode input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Force a nibble back into the decimal range; anything above 9 reads as 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // True when the lowest `digits` nibbles of vec are all 9.
  function automatic logic is_all_nines(input logic [BCD_W*MAX_DIGITS-1:0] vec,
                                        input int digits);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && vec[i*BCD_W +: BCD_W] != BCD_MAX) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and result bundle between a controller and the BCD counter.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  mode;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   number;
  logic                  zero;
  logic                  tc;

  // Controller side: drives controls, observes the count.
  modport master (
    output en, mode, load, load_val,
    input  number, zero, tc
  );

  // Counter side.
  modport slave (
    input  en, mode, load, load_val,
    output number, zero, tc
  );
endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the cascaded counter: load, step up/down, rollover flag.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       mode,
  input  logic       wrap_en,
  output logic [3:0] digit,
  output logic       roll
);

  logic [3:0] digit_q, digit_d;

  // Digit sits at the value from which the next step carries/borrows.
  assign roll  = (mode == DIR_UP) ? (digit_q == BCD_MAX) : (digit_q == 4'd0);
  assign digit = digit_q;

  // Next digit value: load has priority, then a step in the selected direction.
  // wrap_en only matters for the top digit; the step chain already blocks a
  // saturating step, so this is a second guard that keeps the top digit put.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (step) begin
      if (roll) begin
        if (wrap_en) digit_d = (mode == DIR_UP) ? 4'd0 : BCD_MAX;
      end else begin
        digit_d = (mode == DIR_UP) ? digit_q + 4'd1 : digit_q - 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) digit_q <= 4'd0;
    else     digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, wrap/saturate and terminal-count
// pulse. Outputs are registered one cycle behind the internal count.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_updown_counter_if.slave bus
);

  localparam int W = BCD_W * DIGITS;

  logic [DIGITS-1:0][BCD_W-1:0] cnt;
  logic [DIGITS-1:0]            roll;
  logic [DIGITS-1:0]            step;
  logic                         terminal;
  logic                         tc_event;

  logic [W-1:0] number_q, number_d;
  logic         zero_q,   zero_d;
  logic         tc_pend_q, tc_pend_d;
  logic         tc_q,     tc_d;

  // Every digit at its rollover value is exactly all-9 going up or all-0
  // going down, so the terminal test falls out of the roll flags.
  // The step chain ripples from digit 0; a saturating counter at terminal
  // never starts the chain, so every digit holds.
  always_comb begin
    terminal = &roll;
    tc_event = bus.en & ~bus.load & terminal;
    step     = '0;
    step[0]  = bus.en & ~bus.load & ~(terminal & ~WRAP);
    for (int i = 1; i < DIGITS; i++) begin
      step[i] = step[i-1] & roll[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (bus.load),
      .load_digit (bus.load_val[g*BCD_W +: BCD_W]),
      .step       (step[g]),
      .mode       (bus.mode),
      .wrap_en    ((g == DIGITS-1) ? WRAP : 1'b1),
      .digit      (cnt[g]),
      .roll       (roll[g])
    );
  end

  // Output stage: number/zero mirror cnt one edge late. The tc event is
  // delayed twice so the pulse lines up with the wrapped/held value on number.
  always_comb begin
    number_d  = cnt;
    zero_d    = (cnt == '0);
    tc_pend_d = tc_event;
    tc_d      = tc_pend_q;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      number_q  <= '0;
      zero_q    <= 1'b0;
      tc_pend_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      number_q  <= number_d;
      zero_q    <= zero_d;
      tc_pend_q <= tc_pend_d;
      tc_q      <= tc_d;
    end
  end

  assign bus.number = number_q;
  assign bus.zero   = zero_q;
  assign bus.tc     = tc_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: two 2-digit counters (wrap and saturate) share stimulus;
// an integer model predicts outputs, queued per drive and popped per edge.
module tb_bcd_updown_counter;

  typedef struct {
    logic [7:0] num;
    logic       zero;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [7:0] load_val;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   tcw_cnt;
  int   mc[2];
  bit   mp[2];
  exp_t q_w[$];
  exp_t q_s[$];

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(2)) bus_w ();
  bcd_updown_counter_if #(.DIGITS(2)) bus_s ();

  assign bus_w.en = en;  assign bus_w.mode = mode;
  assign bus_w.load = load;  assign bus_w.load_val = load_val;
  assign bus_s.en = en;  assign bus_s.mode = mode;
  assign bus_s.load = load;  assign bus_s.load_val = load_val;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));
  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat  (.clk(clk), .rst(rst), .bus(bus_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int clamp_int(input logic [7:0] v);
    int d0, d1;
    d0 = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    d1 = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    return d1 * 10 + d0;
  endfunction

  // Predict this edge for both counters, push, clock, then pop and compare.
  task automatic cyc();
    exp_t e;
    int   old;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mc[k] = 0; mp[k] = 1'b0;
        e.num = 8'h00; e.zero = 1'b0; e.tc = 1'b0;
      end else begin
        old    = mc[k];
        e.num  = to_bcd(old);
        e.zero = (old == 0);
        e.tc   = mp[k];
        mp[k]  = 1'b0;
        if (load) begin
          mc[k] = clamp_int(load_val);
        end else if (en) begin
          if (mode) begin
            if (old == 99) begin mp[k] = 1'b1; mc[k] = (k == 0) ? 0 : 99; end
            else mc[k] = old + 1;
          end else begin
            if (old == 0) begin mp[k] = 1'b1; mc[k] = (k == 0) ? 99 : 0; end
            else mc[k] = old - 1;
          end
        end
      end
      if (k == 0) q_w.push_back(e); else q_s.push_back(e);
    end
    @(posedge clk);
    #1;
    e = q_w.pop_front();
    check("wrap_number", 32'(bus_w.number), 32'(e.num));
    check("wrap_zero",   32'(bus_w.zero),   32'(e.zero));
    check("wrap_tc",     32'(bus_w.tc),     32'(e.tc));
    e = q_s.pop_front();
    check("sat_number",  32'(bus_s.number), 32'(e.num));
    check("sat_zero",    32'(bus_s.zero),   32'(e.zero));
    check("sat_tc",      32'(bus_s.tc),     32'(e.tc));
    if (bus_w.tc) tcw_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b1; load = 1'b0; load_val = 8'h00;
    mc[0] = 0; mc[1] = 0; mp[0] = 1'b0; mp[1] = 1'b0;
    #2;
    cyc(); cyc();
    check("reset_number", 32'(bus_w.number), 32'h00);
    check("reset_zero",   32'(bus_w.zero),   32'h0);
    rst = 1'b0;

    // Full up sweep 00..99 then back to 00 with a single tc pulse.
    en = 1'b1; mode = 1'b1; tcw_cnt = 0;
    for (int i = 0; i < 101; i++) cyc();
    check("sweep_tc_pulses", 32'(tcw_cnt), 32'd1);
    check("sweep_end_num",   32'(bus_w.number), 32'h00);
    check("sweep_end_tc",    32'(bus_w.tc), 32'h1);

    // Carry 39 -> 40, then borrow 40 -> 39 -> 38.
    load = 1'b1; load_val = 8'h39; cyc();
    load = 1'b0; en = 1'b1; mode = 1'b1; cyc();
    check("carry_pre",  32'(bus_w.number), 32'h39);
    cyc();
    check("carry_post", 32'(bus_w.number), 32'h40);
    load = 1'b1; load_val = 8'h40; mode = 1'b0; cyc();
    load = 1'b0; cyc(); cyc(); cyc();
    check("borrow", 32'(bus_w.number), 32'h38);

    // Saturate at 99 going up.
    load = 1'b1; load_val = 8'h98; mode = 1'b1; cyc();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("sat_hold_num", 32'(bus_s.number), 32'h99);
    check("sat_hold_tc",  32'(bus_s.tc),     32'h1);

    // Saturate at 00 going down, then turn around.
    load = 1'b1; load_val = 8'h00; mode = 1'b0; cyc();
    load = 1'b0; cyc(); cyc(); cyc();
    check("sat0_num",  32'(bus_s.number), 32'h00);
    check("sat0_zero", 32'(bus_s.zero),   32'h1);
    check("sat0_tc",   32'(bus_s.tc),     32'h1);
    mode = 1'b1; cyc(); cyc(); cyc();
    check("turn_num", 32'(bus_s.number), 32'h02);
    check("turn_tc",  32'(bus_s.tc),     32'h0);

    // Load clamp, and load beating enable.
    en = 1'b0; load = 1'b1; load_val = 8'hFA; cyc();
    load = 1'b0; cyc();
    check("clamp_num", 32'(bus_w.number), 32'h99);
    check("clamp_tc",  32'(bus_w.tc),     32'h0);
    en = 1'b1; load = 1'b1; load_val = 8'h12; cyc();
    load = 1'b0; en = 1'b0; cyc();
    check("load_wins", 32'(bus_w.number), 32'h12);

    // Reset in the middle of counting.
    load = 1'b1; load_val = 8'h55; cyc();
    load = 1'b0; en = 1'b1; mode = 1'b1; cyc(); cyc();
    rst = 1'b1; cyc();
    check("midrst_num",  32'(bus_w.number), 32'h00);
    check("midrst_zero", 32'(bus_w.zero),   32'h0);
    rst = 1'b0; cyc();
    check("postrst_zero", 32'(bus_w.zero), 32'h1);
    cyc();
    check("resume_num", 32'(bus_w.number), 32'h01);

    // Random mix of all controls.
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      mode     = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      rst      = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
